// File: rtl/rdi_clk_pkg.sv
// Shared encodings for the RDI clock-request controller: FSM states,
// error codes and requester bit positions.
`timescale 1ns/1ps
package rdi_clk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_ACTIVE,
        ST_HOLD,
        ST_RELEASE,
        ST_ERR
    } clk_req_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_RISE_TO  = 2'b01;
    localparam logic [1:0] ERR_FALL_TO  = 2'b10;
    localparam logic [1:0] ERR_ACK_DROP = 2'b11;

    localparam int unsigned REQ_RDI_FSM = 0;
    localparam int unsigned REQ_SB      = 1;
    localparam int unsigned REQ_PM      = 2;

endpackage

// File: rtl/rdi_timeout_cnt.sv
// Saturating cycle counter with synchronous clear; flags when the count
// equals the supplied limit. Shared by the ack-timeout and hold checks.
`timescale 1ns/1ps
module rdi_timeout_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == i_limit);

endmodule

// File: rtl/rdi_clk_req_ctrl.sv
// RDI clock-request sequencer: arbitrates local requesters onto one clock
// handshake, holds the clock after the last request, and traps ack errors.
`timescale 1ns/1ps
module rdi_clk_req_ctrl
    import rdi_clk_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int HOLD_CYCLES    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_adapter_awake,
    input  logic             i_err_clr,
    output logic             o_clk_hs_en,
    output logic             o_clk_ready,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_busy,
    output logic             o_err,
    output logic [1:0]       o_err_code
);

    localparam logic [CNT_W-1:0] LIM_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_HOLD    = CNT_W'(HOLD_CYCLES - 1);

    clk_req_state_t r_state;
    clk_req_state_t w_state_nxt;
    logic [1:0]     r_err_code;
    logic [1:0]     w_err_code_nxt;
    logic           r_clk_hs_en;
    logic           r_clk_ready;
    logic           r_err;
    logic           w_any_req;
    logic           w_expired;
    logic           w_cnt_clr;
    logic           w_cnt_en;
    logic [CNT_W-1:0] w_cnt_limit;

    assign w_any_req   = |i_req;
    assign w_cnt_clr   = (w_state_nxt != r_state);
    assign w_cnt_en    = (r_state == ST_WAIT_ACK) || (r_state == ST_HOLD) ||
                         (r_state == ST_RELEASE);
    assign w_cnt_limit = (r_state == ST_HOLD) ? LIM_HOLD : LIM_TIMEOUT;

    rdi_timeout_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .i_limit   (w_cnt_limit),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // Ack beats a coincident timeout; a dropped request does not abort.
                if (i_adapter_awake) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_expired) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_RISE_TO;
                end
            end
            ST_ACTIVE: begin
                if (!i_adapter_awake) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_ACK_DROP;
                end else if (!w_any_req) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!i_adapter_awake) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_ACK_DROP;
                end else if (w_any_req) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_expired) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!i_adapter_awake) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expired) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_FALL_TO;
                end
            end
            ST_ERR: begin
                if (i_err_clr) begin
                    w_state_nxt    = ST_IDLE;
                    w_err_code_nxt = ERR_NONE;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_err_code_nxt = ERR_NONE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_err_code  <= ERR_NONE;
            r_clk_hs_en <= 1'b0;
            r_clk_ready <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_err_code  <= w_err_code_nxt;
            r_clk_hs_en <= (w_state_nxt == ST_WAIT_ACK) || (w_state_nxt == ST_ACTIVE) ||
                           (w_state_nxt == ST_HOLD);
            r_clk_ready <= (w_state_nxt == ST_ACTIVE) || (w_state_nxt == ST_HOLD);
            r_err       <= (w_state_nxt == ST_ERR);
        end
    end

    assign o_clk_hs_en = r_clk_hs_en;
    assign o_clk_ready = r_clk_ready;
    assign o_gnt       = {N_REQ{r_clk_ready}} & i_req;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_rdi_clk_req_ctrl.sv
// Directed bench for rdi_clk_req_ctrl with TIMEOUT_CYCLES=16, HOLD_CYCLES=8.
// Cycle c means the interval just after the c-th rising edge of a scenario.
`timescale 1ns/1ps
module tb_rdi_clk_req_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [2:0] i_req = 3'b000;
    logic       i_adapter_awake = 1'b0;
    logic       i_err_clr = 1'b0;
    logic       o_clk_hs_en;
    logic       o_clk_ready;
    logic [2:0] o_gnt;
    logic       o_busy;
    logic       o_err;
    logic [1:0] o_err_code;

    int checks = 0;
    int errors = 0;

    rdi_clk_req_ctrl #(
        .N_REQ          (3),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (16),
        .HOLD_CYCLES    (8)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_req           (i_req),
        .i_adapter_awake (i_adapter_awake),
        .i_err_clr       (i_err_clr),
        .o_clk_hs_en     (o_clk_hs_en),
        .o_clk_ready     (o_clk_ready),
        .o_gnt           (o_gnt),
        .o_busy          (o_busy),
        .o_err           (o_err),
        .o_err_code      (o_err_code)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog sim time expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // From ACTIVE with ack high: drop requests, ride out HOLD, then drop ack.
    task automatic drain();
        i_req = 3'b000;
        repeat (9) tick();
        i_adapter_awake = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #3;
        checks++; if (o_clk_hs_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", o_clk_hs_en); end
        checks++; if (o_clk_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", o_clk_ready); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", o_err); end
        checks++; if (o_err_code !== 2'b00) begin errors++; $display("FAIL rst_code got=%b exp=00", o_err_code); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        i_req = 3'b111;
        tick();
        checks++; if (o_gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt got=%b exp=000", o_gnt); end
        i_req = 3'b000;
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic       exp_en, exp_rdy;
        logic [2:0] exp_gnt;
        i_req = 3'b001;
        for (int c = 1; c <= 19; c++) begin
            tick();
            exp_en  = (c >= 1 && c <= 18);
            exp_rdy = (c >= 5 && c <= 18);
            exp_gnt = (c >= 5 && c <= 10) ? 3'b001 : 3'b000;
            checks++; if (o_clk_hs_en !== exp_en) begin errors++; $display("FAIL basic_en c%0d got=%b exp=%b", c, o_clk_hs_en, exp_en); end
            checks++; if (o_clk_ready !== exp_rdy) begin errors++; $display("FAIL basic_ready c%0d got=%b exp=%b", c, o_clk_ready, exp_rdy); end
            checks++; if (o_gnt !== exp_gnt) begin errors++; $display("FAIL basic_gnt c%0d got=%b exp=%b", c, o_gnt, exp_gnt); end
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy c%0d got=%b exp=1", c, o_busy); end
            if (c == 4)  i_adapter_awake = 1'b1;
            if (c == 10) i_req = 3'b000;
        end
        i_adapter_awake = 1'b0;
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", o_busy); end
        checks++; if (o_clk_hs_en !== 1'b0) begin errors++; $display("FAIL basic_idle_en got=%b exp=0", o_clk_hs_en); end
    endtask

    task automatic test_hold_rearm();
        i_req = 3'b010;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++; if (o_clk_hs_en !== 1'b1) begin errors++; $display("FAIL hold_en c%0d got=%b exp=1", c, o_clk_hs_en); end
            if (c >= 2) begin
                checks++; if (o_clk_ready !== 1'b1) begin errors++; $display("FAIL hold_ready c%0d got=%b exp=1", c, o_clk_ready); end
            end
            if (c == 1) i_adapter_awake = 1'b1;
            if (c == 3) i_req = 3'b000;
            if (c == 8) begin
                i_req = 3'b010;
                #1;
                checks++; if (o_gnt !== 3'b010) begin errors++; $display("FAIL hold_gnt got=%b exp=010", o_gnt); end
            end
            if (c == 10) i_req = 3'b000;
            if (c == 18) i_req = 3'b010;
        end
        i_req = 3'b000;
        repeat (9) tick();
        checks++; if (o_clk_hs_en !== 1'b0) begin errors++; $display("FAIL hold_rel_en got=%b exp=0", o_clk_hs_en); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL hold_rel_busy got=%b exp=1", o_busy); end
        i_adapter_awake = 1'b0;
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL hold_idle got=%b exp=0", o_busy); end
    endtask

    task automatic test_rise_timeout();
        i_req = 3'b001;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c <= 16) begin
                checks++; if (o_err !== 1'b0 || o_clk_hs_en !== 1'b1) begin errors++; $display("FAIL rise_wait c%0d err=%b en=%b exp err=0 en=1", c, o_err, o_clk_hs_en); end
            end
        end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rise_err got=%b exp=1", o_err); end
        checks++; if (o_err_code !== 2'b01) begin errors++; $display("FAIL rise_code got=%b exp=01", o_err_code); end
        checks++; if (o_clk_hs_en !== 1'b0 || o_clk_ready !== 1'b0) begin errors++; $display("FAIL rise_outs en=%b ready=%b exp 0 0", o_clk_hs_en, o_clk_ready); end
        checks++; if (o_gnt !== 3'b000) begin errors++; $display("FAIL rise_gnt got=%b exp=000", o_gnt); end
        i_req = 3'b000;
        tick();
        checks++; if (o_err !== 1'b1 || o_err_code !== 2'b01) begin errors++; $display("FAIL rise_sticky err=%b code=%b exp 1 01", o_err, o_err_code); end
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        checks++; if (o_err !== 1'b0 || o_err_code !== 2'b00) begin errors++; $display("FAIL rise_clr err=%b code=%b exp 0 00", o_err, o_err_code); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rise_clr_busy got=%b exp=0", o_busy); end
        // Ack arriving on the final timeout cycle must win.
        i_req = 3'b001;
        repeat (16) tick();
        i_adapter_awake = 1'b1;
        tick();
        checks++; if (o_clk_ready !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL rise_ack_wins ready=%b err=%b exp 1 0", o_clk_ready, o_err); end
        drain();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rise_drain_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_fall_and_drop();
        i_req = 3'b001;
        tick();
        i_adapter_awake = 1'b1;
        tick();
        checks++; if (o_clk_ready !== 1'b1) begin errors++; $display("FAIL fall_ready got=%b exp=1", o_clk_ready); end
        i_req = 3'b000;
        for (int c = 3; c <= 27; c++) begin
            tick();
            if (c == 10) begin
                checks++; if (o_clk_hs_en !== 1'b1) begin errors++; $display("FAIL fall_hold_en got=%b exp=1", o_clk_hs_en); end
            end
            if (c == 11) begin
                checks++; if (o_clk_hs_en !== 1'b0) begin errors++; $display("FAIL fall_rel_en got=%b exp=0", o_clk_hs_en); end
            end
            if (c == 26) begin
                checks++; if (o_err !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL fall_pre err=%b busy=%b exp 0 1", o_err, o_busy); end
            end
        end
        checks++; if (o_err !== 1'b1 || o_err_code !== 2'b10) begin errors++; $display("FAIL fall_code err=%b code=%b exp 1 10", o_err, o_err_code); end
        i_adapter_awake = 1'b0;
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        checks++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL fall_clr err=%b busy=%b exp 0 0", o_err, o_busy); end
        i_req = 3'b001;
        tick();
        i_adapter_awake = 1'b1;
        tick();
        checks++; if (o_gnt !== 3'b001) begin errors++; $display("FAIL drop_gnt got=%b exp=001", o_gnt); end
        i_adapter_awake = 1'b0;
        tick();
        checks++; if (o_err !== 1'b1 || o_err_code !== 2'b11) begin errors++; $display("FAIL drop_code err=%b code=%b exp 1 11", o_err, o_err_code); end
        checks++; if (o_clk_ready !== 1'b0 || o_gnt !== 3'b000) begin errors++; $display("FAIL drop_ready ready=%b gnt=%b exp 0 000", o_clk_ready, o_gnt); end
        i_req = 3'b000;
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        checks++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL drop_clr err=%b busy=%b exp 0 0", o_err, o_busy); end
    endtask

    task automatic test_multi_req();
        logic exp_en, exp_rdy;
        i_req = 3'b111;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_en  = (c <= 15);
            exp_rdy = (c >= 2 && c <= 15);
            checks++; if (o_clk_hs_en !== exp_en) begin errors++; $display("FAIL multi_en c%0d got=%b exp=%b", c, o_clk_hs_en, exp_en); end
            checks++; if (o_clk_ready !== exp_rdy) begin errors++; $display("FAIL multi_ready c%0d got=%b exp=%b", c, o_clk_ready, exp_rdy); end
            if (c == 1) i_adapter_awake = 1'b1;
            if (c == 2) begin
                checks++; if (o_gnt !== 3'b111) begin errors++; $display("FAIL multi_gnt111 got=%b exp=111", o_gnt); end
            end
            if (c == 3) begin
                i_req = 3'b110;
                #1;
                checks++; if (o_gnt !== 3'b110) begin errors++; $display("FAIL multi_gnt110 got=%b exp=110", o_gnt); end
            end
            if (c == 5) i_req = 3'b100;
            if (c == 7) i_req = 3'b000;
        end
        i_adapter_awake = 1'b0;
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL multi_idle got=%b exp=0", o_busy); end
    endtask

    task automatic test_reset_mid();
        i_req = 3'b001;
        tick();
        i_adapter_awake = 1'b1;
        tick();
        checks++; if (o_clk_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", o_clk_ready); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_clk_hs_en !== 1'b0 || o_clk_ready !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL rmid_outs en=%b ready=%b err=%b exp 0 0 0", o_clk_hs_en, o_clk_ready, o_err); end
        checks++; if (o_gnt !== 3'b000 || o_busy !== 1'b0) begin errors++; $display("FAIL rmid_gnt gnt=%b busy=%b exp 000 0", o_gnt, o_busy); end
        i_req = 3'b000;
        i_adapter_awake = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        checks++; if (o_clk_hs_en !== 1'b0) begin errors++; $display("FAIL rmid_c0_en got=%b exp=0", o_clk_hs_en); end
        i_req = 3'b001;
        tick();
        checks++; if (o_clk_hs_en !== 1'b1) begin errors++; $display("FAIL rmid_c1_en got=%b exp=1", o_clk_hs_en); end
        i_adapter_awake = 1'b1;
        tick();
        drain();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_drain got=%b exp=0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_rearm();
        test_rise_timeout();
        test_fall_and_drop();
        test_multi_req();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
